afe_tx_streamer: RTL
====================

AFE_TX_STREAMER -- requirements
Module: afe_tx_streamer

Interface
REQ-001 Parameter L2_AWIDTH_NOAL, default 12, SHALL set the L2 word-unaligned address width.
REQ-002 Parameter L2_TRANS_SIZE, default 16, SHALL set the transfer-size and byte-counter width.
REQ-003 Parameter AFE_DATA_WIDTH, default 32, SHALL set the AFE output word width; only 32 is supported.
REQ-004 Parameters AFE_CHID_LSB (28) and AFE_CHID_WIDTH (4) SHALL locate the channel-ID field in the output word.
REQ-005 Parameter FIFO_DEPTH, default 4, SHALL set the output FIFO depth; it SHALL be a power of 2 and at least 2.
REQ-006 Ports (name  direction  width  meaning):
clk_i  in  1  single clock, rising edge.
rst_i  in  1  synchronous reset, active-high.
cfg_startaddr_i  in  L2_AWIDTH_NOAL  byte start address, 4-aligned.
cfg_size_i  in  L2_TRANS_SIZE  transfer length in bytes, multiple of 4.
cfg_continuous_i  in  1  wrap to the start address on completion.
cfg_chid_i  in  AFE_CHID_WIDTH  channel ID inserted into each output word.
cfg_en_i  in  1  start pulse.
cfg_clr_i  in  1  abort pulse.
cfg_en_o  out  1  transfer active.
cfg_bytes_left_o  out  L2_TRANS_SIZE  bytes not yet requested.
l2_req_o  out  1  L2 read request.
l2_addr_o  out  L2_AWIDTH_NOAL  L2 read address.
l2_gnt_i  in  1  request accepted.
l2_rvalid_i  in  1  read data valid; returns in order, at least 1 cycle after grant.
l2_rdata_i  in  32  read data.
afe_valid_o  out  1  output word valid.
afe_ready_i  in  1  AFE accepts the word.
afe_data_o  out  AFE_DATA_WIDTH  output word.
event_o  out  1  one-cycle completion pulse.

Function
REQ-007 The FSM SHALL have three states: IDLE, RUN and DRAIN; cfg_en_o SHALL be 1 in every state except IDLE.
REQ-008 IDLE->RUN SHALL occur on cfg_en_i only when cfg_size_i!=0 and outstanding==0; on that transition, current address = cfg_startaddr_i and bytes_left = cfg_size_i; otherwise cfg_en_i SHALL be ignored.
REQ-009 In RUN, l2_req_o SHALL be 1 iff (fifo_count + outstanding) < FIFO_DEPTH; l2_addr_o SHALL equal the current address.
REQ-010 A request is transferred when l2_req_o & l2_gnt_i; l2_req_o and l2_addr_o SHALL be held stable until granted.
REQ-011 Each grant SHALL advance the address by 4, decrement bytes_left by 4 and increment outstanding; each l2_rvalid_i SHALL decrement outstanding; a simultaneous grant and rvalid SHALL leave outstanding unchanged.
REQ-012 Grant of the last word (bytes_left==4) with cfg_continuous_i=1 SHALL reload the address to cfg_startaddr_i and bytes_left to cfg_size_i, stay in RUN and pulse event_o in the next cycle.
REQ-013 Grant of the last word with cfg_continuous_i=0 SHALL set bytes_left to 0 and move to DRAIN; l2_req_o SHALL be 0 in DRAIN.
REQ-014 DRAIN->IDLE SHALL occur when outstanding==0, the FIFO is empty and no handshake is in flight; event_o SHALL pulse in the cycle after that transition.
REQ-015 Each l2_rvalid_i received while not discarding SHALL push l2_rdata_i into the FIFO; the accounting rule in REQ-009 guarantees no overflow; an overflow SHALL be an assertion failure.
REQ-016 afe_valid_o SHALL be 1 iff the FIFO is not empty; the FIFO SHALL pop on afe_valid_o & afe_ready_i; afe_data_o SHALL be held stable while afe_valid_o & ~afe_ready_i.
REQ-017 afe_data_o SHALL equal the FIFO head with bits [AFE_CHID_LSB +: AFE_CHID_WIDTH] replaced by the cfg_chid_i value latched at start; all other bits SHALL pass through unchanged.
REQ-018 A push and a pop in the same cycle SHALL leave fifo_count unchanged, including when the FIFO is full (push permitted only if pop occurs).
REQ-019 cfg_clr_i in any state SHALL, in the next cycle:
- return the FSM to IDLE;
- flush the FIFO;
- drop l2_req_o;
- zero bytes_left.
Responses still outstanding SHALL be discarded; there is no event_o.
REQ-020 cfg_clr_i SHALL take priority over a simultaneous cfg_en_i.
REQ-021 The outstanding counter SHALL be ceil(log2(FIFO_DEPTH+1)) bits wide.
REQ-022 The address counter SHALL wrap modulo 2^L2_AWIDTH_NOAL.

Reset
REQ-023 With rst_i=1 at a clk_i edge, the block SHALL set:
- state = IDLE;
- FIFO and outstanding = 0;
- cfg_en_o, l2_req_o, afe_valid_o, event_o = 0;
- cfg_bytes_left_o = 0;
- l2_addr_o = 0;
- afe_data_o = 0.
REQ-024 Reset mid-transfer SHALL behave as REQ-023, and responses arriving after reset SHALL be ignored.

Verification
REQ-025 Start 0x100, size 16, non-continuous, grant immediately, rvalid 1 cycle later, ready=1 -> 4 requests at 0x100/0x104/0x108/0x10C; 4 output words with CHID=cfg_chid; single event_o; cfg_en_o=0 at end.
REQ-026 afe_ready_i=0 for 20 cycles, FIFO_DEPTH=4 -> at most 4 requests issued; l2_req_o=0 until a pop; no data lost; order preserved.
REQ-027 Continuous mode, size 8 -> addresses 0x100,0x104,0x100,0x104...; event_o every 2nd grant; cfg_bytes_left_o reloads to 8.
REQ-028 cfg_clr_i with 2 responses outstanding -> IDLE next cycle; the 2 late rvalids produce no output; new cfg_en_i is ignored until outstanding==0, then accepted.
REQ-029 cfg_size_i=0 with cfg_en_i -> stays IDLE, no request, no event_o.
REQ-030 Simultaneous grant+rvalid and push+pop on a full FIFO -> counters unchanged; no overflow assertion fires.

Source files
------------

// File: rtl/afe_tx_streamer_if.sv
// Bus bundle for the AFE TX streamer: L2 read port and AFE output port.
// The master modport is the streamer's view; slave is the L2/AFE side.
interface afe_tx_streamer_if #(
    parameter int L2_AWIDTH_NOAL = 12,
    parameter int AFE_DATA_WIDTH = 32
);
    logic                      l2_req_o;
    logic [L2_AWIDTH_NOAL-1:0] l2_addr_o;
    logic                      l2_gnt_i;
    logic                      l2_rvalid_i;
    logic [31:0]               l2_rdata_i;
    logic                      afe_valid_o;
    logic                      afe_ready_i;
    logic [AFE_DATA_WIDTH-1:0] afe_data_o;

    modport master (
        output l2_req_o, l2_addr_o,
        input  l2_gnt_i, l2_rvalid_i, l2_rdata_i,
        output afe_valid_o, afe_data_o,
        input  afe_ready_i
    );

    modport slave (
        input  l2_req_o, l2_addr_o,
        output l2_gnt_i, l2_rvalid_i, l2_rdata_i,
        input  afe_valid_o, afe_data_o,
        output afe_ready_i
    );
endinterface

// File: rtl/afe_tx_streamer.sv
// AFE TX streamer: reads a linear (optionally wrapping) L2 region word by
// word, buffers responses in a small FIFO and presents them to the AFE with
// the channel-ID field overwritten.
//
// state | meaning
// IDLE  | no transfer; start accepted only when no stale responses remain
// RUN   | issuing L2 reads while FIFO + outstanding has room
// DRAIN | all reads issued; waiting for responses and FIFO to empty
module afe_tx_streamer #(
    parameter int L2_AWIDTH_NOAL = 12,
    parameter int L2_TRANS_SIZE  = 16,
    parameter int AFE_DATA_WIDTH = 32,
    parameter int AFE_CHID_LSB   = 28,
    parameter int AFE_CHID_WIDTH = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [L2_AWIDTH_NOAL-1:0] cfg_startaddr_i,
    input  logic [L2_TRANS_SIZE-1:0]  cfg_size_i,
    input  logic                      cfg_continuous_i,
    input  logic [AFE_CHID_WIDTH-1:0] cfg_chid_i,
    input  logic                      cfg_en_i,
    input  logic                      cfg_clr_i,
    output logic                      cfg_en_o,
    output logic [L2_TRANS_SIZE-1:0]  cfg_bytes_left_o,
    output logic                      event_o,
    afe_tx_streamer_if.master         bus
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW:0]               DEPTH_EXT = (CW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0]             DEPTH_CNT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]             CNT_ONE   = CW'(1);
    localparam logic [PW-1:0]             PTR_ONE   = PW'(1);
    localparam logic [L2_AWIDTH_NOAL-1:0] ADDR_STEP = L2_AWIDTH_NOAL'(4);
    localparam logic [L2_TRANS_SIZE-1:0]  WORD_B    = L2_TRANS_SIZE'(4);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                    r_state;
    logic [L2_AWIDTH_NOAL-1:0] r_addr;
    logic [L2_TRANS_SIZE-1:0]  r_bytes_left;
    logic [CW-1:0]             r_outstanding;
    logic [AFE_CHID_WIDTH-1:0] r_chid;
    logic                      r_event;

    logic [31:0]               r_mem [FIFO_DEPTH];
    logic [PW-1:0]             r_wptr;
    logic [PW-1:0]             r_rptr;
    logic [CW-1:0]             r_count;

    logic                      w_fifo_empty;
    logic                      w_fifo_full;
    logic [CW:0]               w_inflight;
    logic                      w_l2_req;
    logic                      w_grant;
    logic                      w_rsp;
    logic                      w_push;
    logic                      w_push_ok;
    logic                      w_pop;
    logic                      w_last;
    logic                      w_start;
    logic [AFE_DATA_WIDTH-1:0] w_afe_data;

    assign w_fifo_empty = (r_count == '0);
    assign w_fifo_full  = (r_count == DEPTH_CNT);
    // Buffered plus in-flight words never exceed the FIFO, so responses always fit.
    assign w_inflight   = {1'b0, r_count} + {1'b0, r_outstanding};
    assign w_l2_req     = (r_state == S_RUN) && (w_inflight < DEPTH_EXT);
    assign w_grant      = w_l2_req && bus.l2_gnt_i;
    // Responses with nothing outstanding (e.g. left over from before a reset) are ignored.
    assign w_rsp        = bus.l2_rvalid_i && (r_outstanding != '0);
    // In IDLE every remaining response belongs to an aborted transfer.
    assign w_push       = w_rsp && (r_state != S_IDLE) && !cfg_clr_i;
    assign w_pop        = !w_fifo_empty && bus.afe_ready_i;
    assign w_push_ok    = w_push && (!w_fifo_full || w_pop);
    assign w_last       = (r_bytes_left == WORD_B);
    assign w_start      = (r_state == S_IDLE) && cfg_en_i && !cfg_clr_i &&
                          (cfg_size_i != '0) && (r_outstanding == '0);

    // Output word is the FIFO head with the channel-ID field replaced.
    always_comb begin
        w_afe_data = '0;
        if (!w_fifo_empty) begin
            w_afe_data = r_mem[r_rptr];
            w_afe_data[AFE_CHID_LSB +: AFE_CHID_WIDTH] = r_chid;
        end
    end

    assign cfg_en_o         = (r_state != S_IDLE);
    assign cfg_bytes_left_o = r_bytes_left;
    assign event_o          = r_event;
    assign bus.l2_req_o     = w_l2_req;
    assign bus.l2_addr_o    = r_addr;
    assign bus.afe_valid_o  = !w_fifo_empty;
    assign bus.afe_data_o   = w_afe_data;

    // Transfer sequencing, address/byte counters and outstanding-read tracking.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= S_IDLE;
            r_addr        <= '0;
            r_bytes_left  <= '0;
            r_outstanding <= '0;
            r_chid        <= '0;
            r_event       <= 1'b0;
        end else begin
            r_event <= 1'b0;
            // Aborted reads still return, so grants and responses are counted regardless of clear.
            case ({w_grant, w_rsp})
                2'b10:   r_outstanding <= r_outstanding + CNT_ONE;
                2'b01:   r_outstanding <= r_outstanding - CNT_ONE;
                default: r_outstanding <= r_outstanding;
            endcase
            if (cfg_clr_i) begin
                r_state      <= S_IDLE;
                r_bytes_left <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_start) begin
                            r_state      <= S_RUN;
                            r_addr       <= cfg_startaddr_i;
                            r_bytes_left <= cfg_size_i;
                            r_chid       <= cfg_chid_i;
                        end
                    end
                    S_RUN: begin
                        if (w_grant) begin
                            if (w_last && cfg_continuous_i) begin
                                r_addr       <= cfg_startaddr_i;
                                r_bytes_left <= cfg_size_i;
                                r_event      <= 1'b1;
                            end else if (w_last) begin
                                r_addr       <= r_addr + ADDR_STEP;
                                r_bytes_left <= '0;
                                r_state      <= S_DRAIN;
                            end else begin
                                r_addr       <= r_addr + ADDR_STEP;
                                r_bytes_left <= r_bytes_left - WORD_B;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if ((r_outstanding == '0) && w_fifo_empty && !bus.l2_rvalid_i) begin
                            r_state <= S_IDLE;
                            r_event <= 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // FIFO pointers and occupancy; clear flushes everything at once.
    always_ff @(posedge clk_i) begin
        if (rst_i || cfg_clr_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)     r_rptr <= r_rptr + PTR_ONE;
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents need no reset since the output is gated by occupancy.
    always_ff @(posedge clk_i) begin
        if (w_push_ok && !rst_i && !cfg_clr_i) begin
            r_mem[r_wptr] <= bus.l2_rdata_i;
        end
    end

    // A push into a full FIFO without a pop means the request throttling is broken.
    always_ff @(posedge clk_i) begin
        if (!rst_i && !cfg_clr_i) begin
            assert (!(w_push && w_fifo_full && !w_pop));
        end
    end

endmodule
